sume_clk_reset_sequencer: RTL and testbench
===========================================

Name: sume_clk_reset_sequencer

Overview:
Board bring-up controller for the 10G datapath on the reference NIC.
- Holds the SI5324 jitter attenuator in reset, then triggers its I2C programming, then waits for the 156.25 MHz PLL to lock stably.
- After lock, pulses the 10G PHY reset and finally releases the core datapath reset.
- Monitors lock loss while running and re-sequences; drives led_0/led_1 status.
- Sits beside the I2C master and the xphy block in the top level.

Parameters:
RST_HOLD_CYCLES, 1000, cycles si5324_rst_n held low (>=1)
I2C_TIMEOUT, 1048576, cycles allowed for i2c_done after i2c_start (>=2)
MAX_RETRIES, 3, I2C programming retries before FAIL (0..15)
LOCK_STABLE_CYCLES, 4096, consecutive cycles pll_locked must stay high (>=1)
XPHY_RST_CYCLES, 64, cycles xphy_rst held high after lock (>=1)
LED_DIV_BITS, 24, heartbeat divider width; led blink period 2^LED_DIV_BITS cycles

Ports:
clk  in  1  free-running 200 MHz reference clock
reset  in  1  synchronous, active-high
i2c_done  in  1  one-cycle pulse: I2C programming sequence finished
i2c_error  in  1  qualifies i2c_done; 1 = NACK/failure
pll_locked  in  1  SI5324/QPLL lock, already synchronised to clk
pcie_link_up  in  1  PCIe link status, synchronised to clk
si5324_rst_n  out  1  SI5324 reset, active-low
i2c_start  out  1  one-cycle pulse requesting I2C programming
xphy_rst  out  1  10G PHY reset, active-high
core_rst  out  1  datapath reset, active-high
seq_state  out  3  current FSM state encoding
retry_cnt  out  4  I2C retries consumed
led_0  out  1  status LED
led_1  out  1  fail LED

Behaviour:
- Single clock domain. All outputs are registered.
- Reset values: si5324_rst_n=0, i2c_start=0, xphy_rst=1, core_rst=1, seq_state=HOLD, retry_cnt=0, led_0=0, led_1=0.
- Reset asserted in any state returns to HOLD on the next edge and clears all counters. There is no partial state.
- State encoding: HOLD=0, PROG=1, PWAIT=2, LOCK=3, XRST=4, RUN=5, FAIL=6.
- HOLD:
  - si5324_rst_n=0.
  - Counter runs RST_HOLD_CYCLES cycles, then go to PROG.
  - si5324_rst_n rises on the same edge as the state change.
- PROG: i2c_start=1 for exactly one cycle, then go to PWAIT. The timeout counter is cleared.
- PWAIT:
  - i2c_done && !i2c_error -> LOCK.
  - i2c_done && i2c_error, or timeout counter reaching I2C_TIMEOUT-1 without done:
    - if retry_cnt==MAX_RETRIES -> FAIL;
    - else retry_cnt+1 and go to HOLD (full SI5324 reset re-applied).
  - i2c_done arriving on the timeout cycle counts as done; done wins.
  - i2c_done outside PWAIT is ignored.
- LOCK:
  - Stability counter increments while pll_locked=1 and clears to 0 on any cycle with pll_locked=0.
  - When the counter reaches LOCK_STABLE_CYCLES-1 with pll_locked=1 -> XRST.
  - No timeout in this state.
- XRST:
  - xphy_rst=1 for XPHY_RST_CYCLES cycles, then go to RUN.
  - pll_locked=0 during XRST -> LOCK, counter cleared.
- RUN:
  - xphy_rst=0; core_rst=0, registered, so it falls on the first RUN cycle.
  - pll_locked=0 -> LOCK. On that same edge core_rst=1 and xphy_rst=1. Stay there until re-locked; no I2C reprogram.
  - retry_cnt holds its value.
- FAIL: terminal until reset. Outputs: si5324_rst_n=0, xphy_rst=1, core_rst=1.
- xphy_rst=1 in every state except RUN. core_rst=1 in every state except RUN.
- LEDs:
  - led_0 = divider MSB (heartbeat) in RUN when pcie_link_up=1.
  - led_0 = 1 steady in RUN when pcie_link_up=0.
  - led_0 = 0 in all other states.
  - led_1 = divider MSB in FAIL, else 0.
  - The divider is free-running and cleared only by reset.
- Counter widths: clog2 of the largest of RST_HOLD_CYCLES, I2C_TIMEOUT, LOCK_STABLE_CYCLES and XPHY_RST_CYCLES, plus 1. Counters do not wrap.

Test Plan (RST_HOLD_CYCLES=8, I2C_TIMEOUT=16, MAX_RETRIES=2, LOCK_STABLE_CYCLES=10, XPHY_RST_CYCLES=4, LED_DIV_BITS=3):
1. Nominal bring-up.
   - Stimulus: reset 5 cycles; i2c_done 3 cycles after i2c_start; pll_locked high throughout.
   - Required: si5324_rst_n rises 8 cycles after reset release; a single i2c_start pulse; core_rst falls exactly 10+4 cycles after LOCK entry; seq_state=5.
2. I2C error retry.
   - Stimulus: first i2c_done with i2c_error=1, second done clean.
   - Required: si5324_rst_n goes low again for 8 cycles; retry_cnt=1; reaching RUN.
3. Timeout exhaustion.
   - Stimulus: never pulse i2c_done.
   - Required: 3 i2c_start pulses, each 16 PWAIT cycles apart plus HOLD; seq_state=6; led_1 toggles every 4 cycles; core_rst stays 1.
4. Lock glitch.
   - Stimulus: pll_locked drops for 1 cycle at stability count 7.
   - Required: counter restarts; XRST is entered 10 cycles after lock returns.
5. Loss of lock in RUN.
   - Stimulus: pll_locked=0 for 1 cycle.
   - Required: core_rst=1 and xphy_rst=1 on the next edge; no new i2c_start; RUN is re-entered after 10+4 cycles.
6. Mid-sequence reset and LED behaviour.
   - Stimulus: reset asserted in PWAIT.
   - Required: all outputs at reset values the next cycle and retry_cnt=0.
   - Stimulus: in RUN, toggle pcie_link_up.
   - Required: led_0 steady 1 with link down; led_0 blinks with period 8 with link up.

Source files
------------

// File: rtl/sume_clk_reset_sequencer.sv
// Board bring-up sequencer for the 10G datapath: SI5324 reset, I2C programming,
// PLL lock qualification, PHY reset pulse, then core release with lock-loss recovery.
module sume_clk_reset_sequencer #(
   parameter int RST_HOLD_CYCLES    = 1000,
   parameter int I2C_TIMEOUT        = 1048576,
   parameter int MAX_RETRIES        = 3,
   parameter int LOCK_STABLE_CYCLES = 4096,
   parameter int XPHY_RST_CYCLES    = 64,
   parameter int LED_DIV_BITS       = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_done,
   input  logic       i2c_error,
   input  logic       pll_locked,
   input  logic       pcie_link_up,
   output logic       si5324_rst_n,
   output logic       i2c_start,
   output logic       xphy_rst,
   output logic       core_rst,
   output logic [2:0] seq_state,
   output logic [3:0] retry_cnt,
   output logic       led_0,
   output logic       led_1
);

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      PROG  = 3'd1,
      PWAIT = 3'd2,
      LOCK  = 3'd3,
      XRST  = 3'd4,
      RUN   = 3'd5,
      FAIL  = 3'd6
   } state_e;

   localparam int MaxAB  = (RST_HOLD_CYCLES > I2C_TIMEOUT) ? RST_HOLD_CYCLES : I2C_TIMEOUT;
   localparam int MaxCD  = (LOCK_STABLE_CYCLES > XPHY_RST_CYCLES) ? LOCK_STABLE_CYCLES : XPHY_RST_CYCLES;
   localparam int CntMax = (MaxAB > MaxCD) ? MaxAB : MaxCD;
   localparam int CntW   = $clog2(CntMax) + 1;

   localparam logic [CntW-1:0] HoldLast    = CntW'(RST_HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(I2C_TIMEOUT - 1);
   localparam logic [CntW-1:0] LockLast    = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] XrstLast    = CntW'(XPHY_RST_CYCLES - 1);
   localparam logic [3:0]      RetryLimit  = 4'(MAX_RETRIES);

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [3:0]              retry_q, retry_d;
   logic [LED_DIV_BITS-1:0] div_q, div_d;
   logic                    siRstN_q, siRstN_d;
   logic                    i2cStart_q, i2cStart_d;
   logic                    xphyRst_q, xphyRst_d;
   logic                    coreRst_q, coreRst_d;
   logic                    led0_q, led0_d;
   logic                    led1_q, led1_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= HOLD;
         cnt_q      <= '0;
         retry_q    <= '0;
         div_q      <= '0;
         siRstN_q   <= 1'b0;
         i2cStart_q <= 1'b0;
         xphyRst_q  <= 1'b1;
         coreRst_q  <= 1'b1;
         led0_q     <= 1'b0;
         led1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         div_q      <= div_d;
         siRstN_q   <= siRstN_d;
         i2cStart_q <= i2cStart_d;
         xphyRst_q  <= xphyRst_d;
         coreRst_q  <= coreRst_d;
         led0_q     <= led0_d;
         led1_q     <= led1_d;
      end
   end

   // Every phase transition restarts the shared counter; RUN and FAIL leave it idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      case (state_q)
         HOLD: begin
            if (cnt_q == HoldLast) begin
               state_d = PROG;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PROG: begin
            state_d = PWAIT;
            cnt_d   = '0;
         end
         PWAIT: begin
            if (i2c_done && !i2c_error) begin
               state_d = LOCK;
               cnt_d   = '0;
            end else if (i2c_done || (cnt_q == TimeoutLast)) begin
               cnt_d = '0;
               if (retry_q == RetryLimit) begin
                  state_d = FAIL;
               end else begin
                  state_d = HOLD;
                  retry_d = retry_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LOCK: begin
            if (!pll_locked) begin
               cnt_d = '0;
            end else if (cnt_q == LockLast) begin
               state_d = XRST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         XRST: begin
            if (!pll_locked) begin
               state_d = LOCK;
               cnt_d   = '0;
            end else if (cnt_q == XrstLast) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!pll_locked) begin
               state_d = LOCK;
               cnt_d   = '0;
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_comb begin
      div_d      = div_q + 1'b1;
      siRstN_d   = !((state_d == HOLD) || (state_d == FAIL));
      i2cStart_d = (state_d == PROG);
      xphyRst_d  = (state_d != RUN);
      coreRst_d  = (state_d != RUN);
      led0_d     = 1'b0;
      led1_d     = 1'b0;
      if (state_d == RUN) begin
         led0_d = pcie_link_up ? div_d[LED_DIV_BITS-1] : 1'b1;
      end
      if (state_d == FAIL) begin
         led1_d = div_d[LED_DIV_BITS-1];
      end
   end

   assign si5324_rst_n = siRstN_q;
   assign i2c_start    = i2cStart_q;
   assign xphy_rst     = xphyRst_q;
   assign core_rst     = coreRst_q;
   assign seq_state    = state_q;
   assign retry_cnt    = retry_q;
   assign led_0        = led0_q;
   assign led_1        = led1_q;

endmodule

// File: tb/tb_sume_clk_reset_sequencer.sv
// Testbench for sume_clk_reset_sequencer: directed bring-up scenarios followed by
// randomized stimulus, all checked each cycle against a phase-timer reference model.
module tb_sume_clk_reset_sequencer;

   localparam int RST_HOLD_CYCLES    = 8;
   localparam int I2C_TIMEOUT        = 16;
   localparam int MAX_RETRIES        = 2;
   localparam int LOCK_STABLE_CYCLES = 10;
   localparam int XPHY_RST_CYCLES    = 4;
   localparam int LED_DIV_BITS       = 3;

   localparam int S_HOLD = 0, S_PROG = 1, S_PWAIT = 2, S_LOCK = 3;
   localparam int S_XRST = 4, S_RUN = 5, S_FAIL = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       i2c_done, i2c_error, pll_locked, pcie_link_up;
   logic       si5324_rst_n, i2c_start, xphy_rst, core_rst, led_0, led_1;
   logic [2:0] seq_state;
   logic [3:0] retry_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sume_clk_reset_sequencer #(
      .RST_HOLD_CYCLES   (RST_HOLD_CYCLES),
      .I2C_TIMEOUT       (I2C_TIMEOUT),
      .MAX_RETRIES       (MAX_RETRIES),
      .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
      .XPHY_RST_CYCLES   (XPHY_RST_CYCLES),
      .LED_DIV_BITS      (LED_DIV_BITS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i2c_done     (i2c_done),
      .i2c_error    (i2c_error),
      .pll_locked   (pll_locked),
      .pcie_link_up (pcie_link_up),
      .si5324_rst_n (si5324_rst_n),
      .i2c_start    (i2c_start),
      .xphy_rst     (xphy_rst),
      .core_rst     (core_rst),
      .seq_state    (seq_state),
      .retry_cnt    (retry_cnt),
      .led_0        (led_0),
      .led_1        (led_1)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: the current phase plus how many cycles have elapsed in it,
   // with each phase ending when its elapsed time reaches the configured duration.
   int mPhase, mElapsed, mRetries, mCycles;
   bit mLink;
   bit modelValid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         mPhase   = S_HOLD;
         mElapsed = 0;
         mRetries = 0;
         mCycles  = 0;
      end else begin
         mCycles++;
         case (mPhase)
            S_HOLD: begin
               mElapsed++;
               if (mElapsed == RST_HOLD_CYCLES) begin mPhase = S_PROG; mElapsed = 0; end
            end
            S_PROG: begin mPhase = S_PWAIT; mElapsed = 0; end
            S_PWAIT: begin
               mElapsed++;
               if (i2c_done && !i2c_error) begin
                  mPhase = S_LOCK; mElapsed = 0;
               end else if (i2c_done || mElapsed == I2C_TIMEOUT) begin
                  mElapsed = 0;
                  if (mRetries == MAX_RETRIES) mPhase = S_FAIL;
                  else begin mRetries++; mPhase = S_HOLD; end
               end
            end
            S_LOCK: begin
               mElapsed = pll_locked ? mElapsed + 1 : 0;
               if (mElapsed == LOCK_STABLE_CYCLES) begin mPhase = S_XRST; mElapsed = 0; end
            end
            S_XRST: begin
               if (!pll_locked) begin mPhase = S_LOCK; mElapsed = 0; end
               else begin
                  mElapsed++;
                  if (mElapsed == XPHY_RST_CYCLES) begin mPhase = S_RUN; mElapsed = 0; end
               end
            end
            S_RUN: if (!pll_locked) begin mPhase = S_LOCK; mElapsed = 0; end
            default: ;
         endcase
      end
      mLink      = pcie_link_up;
      modelValid = 1'b1;
   end

   // Compare every DUT output against the model once per cycle.
   always @(negedge clk) begin
      if (modelValid) begin
         int heartbeat;
         heartbeat = (mCycles >> (LED_DIV_BITS - 1)) & 1;
         checkOutput("seq_state", 32'(seq_state), mPhase);
         checkOutput("retry_cnt", 32'(retry_cnt), mRetries);
         checkOutput("si5324_rst_n", 32'(si5324_rst_n), (mPhase == S_HOLD || mPhase == S_FAIL) ? 0 : 1);
         checkOutput("i2c_start", 32'(i2c_start), (mPhase == S_PROG) ? 1 : 0);
         checkOutput("xphy_rst", 32'(xphy_rst), (mPhase == S_RUN) ? 0 : 1);
         checkOutput("core_rst", 32'(core_rst), (mPhase == S_RUN) ? 0 : 1);
         checkOutput("led_0", 32'(led_0), (mPhase == S_RUN) ? (mLink ? heartbeat : 1) : 0);
         checkOutput("led_1", 32'(led_1), (mPhase == S_FAIL) ? heartbeat : 0);
      end
   end

   // Record the cycle of every i2c_start pulse.
   int cyc = 0;
   int startTimes[$];
   always @(negedge clk) begin
      cyc++;
      if (i2c_start === 1'b1) startTimes.push_back(cyc);
   end

   task automatic doReset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input int delay, input bit err);
      repeat (delay) @(negedge clk);
      i2c_done  = 1'b1;
      i2c_error = err;
      @(negedge clk);
      i2c_done  = 1'b0;
      i2c_error = 1'b0;
   endtask

   task automatic waitState(input int s, input int budget, input string name);
      int n = 0;
      while (32'(seq_state) !== s && n < budget) begin @(negedge clk); n++; end
      checkOutput(name, 32'(seq_state), s);
   endtask

   task automatic waitStart(input int budget, input string name);
      int n = 0;
      while (i2c_start !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      checkOutput(name, 32'(i2c_start), 1);
   endtask

   task automatic countToggles(input int intervals, output int tog);
      logic prev0, prev1;
      tog = 0;
      prev0 = led_0; prev1 = led_1;
      repeat (intervals) begin
         @(negedge clk);
         if (led_0 !== prev0 || led_1 !== prev1) tog++;
         prev0 = led_0; prev1 = led_1;
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, tog;
      reset = 1'b1; i2c_done = 1'b0; i2c_error = 1'b0;
      pll_locked = 1'b1; pcie_link_up = 1'b0;

      // Nominal bring-up
      startTimes.delete();
      doReset(5);
      n = 0;
      while (si5324_rst_n !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checkOutput("s1_hold_len", n, 8);
      applyStimulus(3, 1'b0);
      waitState(S_LOCK, 50, "s1_lock");
      n = 0;
      while (core_rst !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checkOutput("s1_lock_to_run", n, 14);
      checkOutput("s1_state", 32'(seq_state), 5);
      checkOutput("s1_starts", startTimes.size(), 1);

      // Loss of lock in RUN
      startTimes.delete();
      pll_locked = 1'b0;
      @(negedge clk);
      checkOutput("s5_core_rst", 32'(core_rst), 1);
      checkOutput("s5_xphy_rst", 32'(xphy_rst), 1);
      checkOutput("s5_state", 32'(seq_state), 3);
      pll_locked = 1'b1;
      n = 0;
      while (32'(seq_state) !== 5 && n < 100) begin @(negedge clk); n++; end
      checkOutput("s5_relock_len", n, 14);
      checkOutput("s5_no_start", startTimes.size(), 0);

      // LEDs in RUN
      repeat (8) begin
         @(negedge clk);
         checkOutput("s6_led0_steady", 32'(led_0), 1);
      end
      pcie_link_up = 1'b1;
      @(negedge clk);
      countToggles(16, tog);
      checkOutput("s6_led0_toggles", tog, 4);
      pcie_link_up = 1'b0;

      // Lock glitch at stability count 7
      doReset(3);
      waitStart(50, "s4_start");
      applyStimulus(3, 1'b0);
      waitState(S_LOCK, 50, "s4_lock");
      repeat (7) @(negedge clk);
      pll_locked = 1'b0;
      @(negedge clk);
      checkOutput("s4_still_lock", 32'(seq_state), 3);
      pll_locked = 1'b1;
      n = 0;
      while (32'(seq_state) !== 4 && n < 100) begin @(negedge clk); n++; end
      checkOutput("s4_relock_len", n, 10);

      // I2C error retry
      doReset(3);
      waitStart(50, "s2_start1");
      applyStimulus(3, 1'b1);
      n = 0;
      while (si5324_rst_n !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      checkOutput("s2_rst_low", 32'(si5324_rst_n), 0);
      n = 0;
      while (si5324_rst_n !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checkOutput("s2_hold_len", n, 8);
      checkOutput("s2_retry", 32'(retry_cnt), 1);
      applyStimulus(3, 1'b0);
      waitState(S_RUN, 100, "s2_run");
      checkOutput("s2_retry_run", 32'(retry_cnt), 1);

      // Reset while waiting for I2C
      doReset(3);
      waitStart(50, "s6_start1");
      applyStimulus(3, 1'b1);
      waitStart(50, "s6_start2");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("s6_rst_n", 32'(si5324_rst_n), 0);
      checkOutput("s6_i2c_start", 32'(i2c_start), 0);
      checkOutput("s6_xphy", 32'(xphy_rst), 1);
      checkOutput("s6_core", 32'(core_rst), 1);
      checkOutput("s6_state", 32'(seq_state), 0);
      checkOutput("s6_retry", 32'(retry_cnt), 0);
      checkOutput("s6_leds", {30'd0, led_1, led_0}, 0);

      // Timeout exhaustion
      startTimes.delete();
      doReset(3);
      waitState(S_FAIL, 200, "s3_fail");
      checkOutput("s3_starts", startTimes.size(), 3);
      checkOutput("s3_gap", (startTimes.size() >= 2) ? startTimes[1] - startTimes[0] : 0, 25);
      checkOutput("s3_core_rst", 32'(core_rst), 1);
      countToggles(16, tog);
      checkOutput("s3_led1_toggles", tog, 4);

      // Randomized stimulus against the model
      doReset(2);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         i2c_done   = ($urandom_range(0, 19) == 0);
         i2c_error  = ($urandom_range(0, 2) == 0);
         pll_locked = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 63) == 0) pcie_link_up = ~pcie_link_up;
         reset      = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      reset = 1'b0; i2c_done = 1'b0; i2c_error = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
